// File: rtl/dsm_pkg.sv
// Shared constants for the 7-level delta-sigma modulator: output levels,
// loop state encoding and the dither LFSR definition.
package dsm_pkg;

  localparam int Q_MIN    = -3;
  localparam int Q_MAX    = 3;
  localparam int V_OFFSET = 3;
  localparam int N_ELEM   = 6;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

  // x^15 + x^14 + 1, shifted left with feedback into bit 0
  localparam logic [14:0] LFSR_SEED = 15'h7FFF;
  localparam logic [14:0] LFSR_TAPS = 15'h6000;

  // Decision level n*S/2 rounded toward +inf, so integer w >= level matches w >= n*S/2
  function automatic int half_step_ceil(input int n, input int s);
    return (n * s + 1) >>> 1;
  endfunction

endpackage

// File: rtl/dsm2_ef7_mod_if.sv
// Sample-side bus of the modulator: PCM input, control strobes and the
// element-count output handed to the mismatch-shaping stage.
interface dsm2_ef7_mod_if #(
  parameter int DW = 16
);

  logic                 clk_en;
  logic signed [DW-1:0] din;
  logic                 mute;
  logic                 ovl_clr;
  logic signed [3:0]    V;
  logic                 ovl;
  logic                 ovl_sticky;

  modport master (
    output clk_en, din, mute, ovl_clr,
    input  V, ovl, ovl_sticky
  );

  modport slave (
    input  clk_en, din, mute, ovl_clr,
    output V, ovl, ovl_sticky
  );

endinterface

// File: rtl/dsm_quant7.sv
// Seven-level mid-tread quantizer: maps w to q in -3..3 with ties rounding up,
// and flags inputs beyond +/-3.5 steps as clamped.
module dsm_quant7
  import dsm_pkg::*;
#(
  parameter int WW      = 21,
  parameter int FB_STEP = 10923
) (
  input  logic signed [WW-1:0] i_w,
  output logic signed [2:0]    o_q,
  output logic                 o_clamp
);

  localparam logic signed [WW-1:0] THR_N7 = WW'(half_step_ceil(-7, FB_STEP));
  localparam logic signed [WW-1:0] THR_N5 = WW'(half_step_ceil(-5, FB_STEP));
  localparam logic signed [WW-1:0] THR_N3 = WW'(half_step_ceil(-3, FB_STEP));
  localparam logic signed [WW-1:0] THR_N1 = WW'(half_step_ceil(-1, FB_STEP));
  localparam logic signed [WW-1:0] THR_P1 = WW'(half_step_ceil( 1, FB_STEP));
  localparam logic signed [WW-1:0] THR_P3 = WW'(half_step_ceil( 3, FB_STEP));
  localparam logic signed [WW-1:0] THR_P5 = WW'(half_step_ceil( 5, FB_STEP));
  localparam logic signed [WW-1:0] THR_P7 = WW'(half_step_ceil( 7, FB_STEP));

  logic [2:0] w_cnt;

  // Thermometer count of crossed levels is directly q - Q_MIN
  always_comb begin
    w_cnt = '0;
    if (i_w >= THR_N5) w_cnt = w_cnt + 3'd1;
    if (i_w >= THR_N3) w_cnt = w_cnt + 3'd1;
    if (i_w >= THR_N1) w_cnt = w_cnt + 3'd1;
    if (i_w >= THR_P1) w_cnt = w_cnt + 3'd1;
    if (i_w >= THR_P3) w_cnt = w_cnt + 3'd1;
    if (i_w >= THR_P5) w_cnt = w_cnt + 3'd1;
    o_q     = $signed(w_cnt - 3'(-Q_MIN));
    o_clamp = (i_w >= THR_P7) || (i_w < THR_N7);
  end

endmodule

// File: rtl/dsm2_ef7_mod.sv
// Second-order error-feedback delta-sigma modulator, NTF (1-z^-1)^2, producing a
// 7-level element count with overload recovery. Define DSM2_DITHER_EN for LFSR dither.
module dsm2_ef7_mod
  import dsm_pkg::*;
#(
  parameter int DW      = 16,
  parameter int IW      = 20,
  parameter int FB_STEP = 10923,
  parameter int OVL_LIM = 4
) (
  input logic            clk,
  input logic            rstn,
  dsm2_ef7_mod_if.slave  bus
);

  localparam int WW = IW + 1;
  localparam logic signed [IW+1:0] W_MAX = (IW+2)'((1 <<< (IW-1)) - 1);
  localparam logic signed [IW+1:0] W_MIN = (IW+2)'(-(1 <<< (IW-1)));
  localparam logic signed [IW-1:0] STEP  = IW'(FB_STEP);

  state_t               r_state;
  logic [3:0]           r_cnt;
  logic signed [IW-1:0] r_e1;
  logic signed [IW-1:0] r_e2;
  logic signed [3:0]    r_v;
  logic                 r_ovl;
  logic                 r_sticky;

  logic signed [DW-1:0] w_x;
  logic signed [IW+1:0] w_wsum;
  logic signed [IW-1:0] w_w;
  logic signed [WW-1:0] w_wd;
  logic signed [2:0]    w_q;
  logic                 w_clamp;
  logic signed [IW-1:0] w_e;
  logic signed [3:0]    w_v;
  logic                 w_trip;

  // Two guard bits hold x - 2*e1 + e2 exactly before saturating back to IW
  always_comb begin
    w_x    = bus.mute ? '0 : bus.din;
    w_wsum = $signed({{(IW+2-DW){w_x[DW-1]}}, w_x})
           - ($signed({{2{r_e1[IW-1]}}, r_e1}) <<< 1)
           + $signed({{2{r_e2[IW-1]}}, r_e2});
    if (w_wsum > W_MAX)
      w_w = {1'b0, {(IW-1){1'b1}}};
    else if (w_wsum < W_MIN)
      w_w = {1'b1, {(IW-1){1'b0}}};
    else
      w_w = w_wsum[IW-1:0];
  end

`ifdef DSM2_DITHER_EN
  localparam logic signed [WW-1:0] DITHER = WW'(FB_STEP / 16);

  logic [14:0] r_lfsr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_lfsr <= LFSR_SEED;
    else if (bus.clk_en)
      r_lfsr <= {r_lfsr[13:0], ^(r_lfsr & LFSR_TAPS)};
  end

  assign w_wd = $signed({w_w[IW-1], w_w}) + (r_lfsr[0] ? DITHER : -DITHER);
`else
  assign w_wd = $signed({w_w[IW-1], w_w});
`endif

  dsm_quant7 #(
    .WW      (WW),
    .FB_STEP (FB_STEP)
  ) u_quant (
    .i_w     (w_wd),
    .o_q     (w_q),
    .o_clamp (w_clamp)
  );

  // e is known to fit in IW bits, so modulo-2^IW arithmetic gives it exactly
  assign w_e    = $signed({{(IW-3){w_q[2]}}, w_q}) * STEP - $signed(w_wd[IW-1:0]);
  assign w_v    = $signed({w_q[2], w_q}) + 4'(V_OFFSET);
  assign w_trip = (r_state == RUN) && w_clamp && (r_cnt == 4'(OVL_LIM - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= RUN;
      r_cnt    <= '0;
      r_e1     <= '0;
      r_e2     <= '0;
      r_v      <= 4'(V_OFFSET);
      r_ovl    <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      if (bus.clk_en) begin
        r_v <= w_v;
        case (r_state)
          RUN: begin
            r_e1 <= w_e;
            r_e2 <= r_e1;
            if (w_trip) begin
              r_state <= RECOVER;
              r_ovl   <= 1'b1;
              r_cnt   <= '0;
            end else if (w_clamp) begin
              r_cnt <= r_cnt + 4'd1;
            end else begin
              r_cnt <= '0;
            end
          end
          RECOVER: begin
            r_e1    <= '0;
            r_e2    <= '0;
            r_state <= RUN;
            r_ovl   <= 1'b0;
            r_cnt   <= '0;
          end
        endcase
      end
      // A new overload wins over a simultaneous clear; the clear itself ignores clk_en
      if (bus.clk_en && w_trip)
        r_sticky <= 1'b1;
      else if (bus.ovl_clr)
        r_sticky <= 1'b0;
    end
  end

  assign bus.V          = r_v;
  assign bus.ovl        = r_ovl;
  assign bus.ovl_sticky = r_sticky;

endmodule

// File: tb/tb_dsm2_ef7_mod.sv
// Directed bench for dsm2_ef7_mod: default-step instance for the datapath and
// a FB_STEP=8192 instance for overload recovery.
module tb_dsm2_ef7_mod;

  typedef struct {
    logic               en;
    logic signed [15:0] din;
    logic               mute;
    logic               clr;
    int                 expV;
    int                 expOvl;
    int                 expSticky;
  } vec_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   nVec  = 0;
  int   nFail = 0;

  vec_t dcVecs[$];
  vec_t ovlVecs[$];
  int   trace[8] = '{3, 4, 4, 3, 3, 4, 4, 3};

  always #5 clk = ~clk;

  dsm2_ef7_mod_if ifd ();
  dsm2_ef7_mod_if ifo ();

  dsm2_ef7_mod u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifd.slave)
  );

  dsm2_ef7_mod #(
    .FB_STEP (8192)
  ) u_dut_ovl (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifo.slave)
  );

  function automatic vec_t mkVec(input logic en, input logic signed [15:0] din,
                                 input logic mute, input logic clr,
                                 input int v, input int o, input int s);
    vec_t r;
    r.en = en; r.din = din; r.mute = mute; r.clr = clr;
    r.expV = v; r.expOvl = o; r.expSticky = s;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic signed [31:0] actual, input int expected);
    nVec++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    nVec++;
    if (actual < lo || actual > hi) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic signed [15:0] din,
                               input logic mute, input logic clr);
    ifd.clk_en  = en;
    ifd.din     = din;
    ifd.mute    = mute;
    ifd.ovl_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic applyOvl(input logic en, input logic signed [15:0] din, input logic clr);
    ifo.clk_en  = en;
    ifo.din     = din;
    ifo.mute    = 1'b0;
    ifo.ovl_clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sum, badRange, ovlSeen, v;

    // Default step S=10923, starting from e1=e2=0
    dcVecs.push_back(mkVec(1'b0,  16'sd1234,  1'b0, 1'b0, 3, 0, 0));
    dcVecs.push_back(mkVec(1'b1,  16'sd0,     1'b0, 1'b0, 3, 0, 0));
    dcVecs.push_back(mkVec(1'b1,  16'sd0,     1'b0, 1'b0, 3, 0, 0));
    dcVecs.push_back(mkVec(1'b1,  16'sd10923, 1'b0, 1'b0, 4, 0, 0));
    dcVecs.push_back(mkVec(1'b1,  16'sd10923, 1'b0, 1'b0, 4, 0, 0));
    dcVecs.push_back(mkVec(1'b0, -16'sd21846, 1'b0, 1'b0, 4, 0, 0));
    dcVecs.push_back(mkVec(1'b1, -16'sd21846, 1'b0, 1'b0, 1, 0, 0));
    dcVecs.push_back(mkVec(1'b1, -16'sd21846, 1'b0, 1'b0, 1, 0, 0));
    dcVecs.push_back(mkVec(1'b1,  16'sd10923, 1'b1, 1'b0, 3, 0, 0));
    dcVecs.push_back(mkVec(1'b1,  16'sd5462,  1'b0, 1'b0, 4, 0, 0));
    dcVecs.push_back(mkVec(1'b1,  16'sd0,     1'b0, 1'b0, 2, 0, 0));
    dcVecs.push_back(mkVec(1'b1,  16'sd0,     1'b0, 1'b0, 4, 0, 0));
    dcVecs.push_back(mkVec(1'b1,  16'sd0,     1'b0, 1'b0, 2, 0, 0));
    dcVecs.push_back(mkVec(1'b1,  16'sd0,     1'b0, 1'b0, 4, 0, 0));
    dcVecs.push_back(mkVec(1'b1,  16'h8000,   1'b0, 1'b0, 0, 0, 0));
    dcVecs.push_back(mkVec(1'b1,  16'h8000,   1'b0, 1'b0, 0, 0, 0));
    dcVecs.push_back(mkVec(1'b1,  16'h8000,   1'b0, 1'b0, 0, 0, 0));
    dcVecs.push_back(mkVec(1'b1,  16'sd0,     1'b0, 1'b0, 1, 0, 0));
    dcVecs.push_back(mkVec(1'b1,  16'sd0,     1'b0, 1'b0, 4, 0, 0));
    dcVecs.push_back(mkVec(1'b1,  16'sd0,     1'b0, 1'b0, 4, 0, 0));
    dcVecs.push_back(mkVec(1'b1,  16'sd0,     1'b0, 1'b0, 2, 0, 0));

    // S=8192, din=+32767 held: four clamps trip, one RECOVER sample, repeat
    ovlVecs.push_back(mkVec(1'b1, 16'sd32767, 1'b0, 1'b0, 6, 0, 0));
    ovlVecs.push_back(mkVec(1'b1, 16'sd32767, 1'b0, 1'b0, 6, 0, 0));
    ovlVecs.push_back(mkVec(1'b1, 16'sd32767, 1'b0, 1'b0, 6, 0, 0));
    ovlVecs.push_back(mkVec(1'b1, 16'sd32767, 1'b0, 1'b0, 6, 1, 1));
    ovlVecs.push_back(mkVec(1'b0, 16'sd32767, 1'b0, 1'b1, 6, 1, 0));
    ovlVecs.push_back(mkVec(1'b1, 16'sd32767, 1'b0, 1'b0, 6, 0, 0));
    ovlVecs.push_back(mkVec(1'b1, 16'sd32767, 1'b0, 1'b0, 6, 0, 0));
    ovlVecs.push_back(mkVec(1'b1, 16'sd32767, 1'b0, 1'b0, 6, 0, 0));
    ovlVecs.push_back(mkVec(1'b1, 16'sd32767, 1'b0, 1'b0, 6, 0, 0));
    ovlVecs.push_back(mkVec(1'b1, 16'sd32767, 1'b0, 1'b1, 6, 1, 1));
    ovlVecs.push_back(mkVec(1'b1, 16'sd32767, 1'b0, 1'b1, 6, 0, 0));
    ovlVecs.push_back(mkVec(1'b1, 16'sd32767, 1'b0, 1'b0, 6, 0, 0));

    ifd.clk_en = 1'b0; ifd.din = '0; ifd.mute = 1'b0; ifd.ovl_clr = 1'b0;
    ifo.clk_en = 1'b0; ifo.din = '0; ifo.mute = 1'b0; ifo.ovl_clr = 1'b0;

    #12;
    checkOutput("reset_V", ifd.V, 3);
    checkOutput("reset_ovl", ifd.ovl, 0);
    checkOutput("reset_sticky", ifd.ovl_sticky, 0);
    checkOutput("reset_V_ovlinst", ifo.V, 3);
    rstn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 16'sd5000, 1'b0, 1'b0);
      checkOutput($sformatf("hold_V[%0d]", i), ifd.V, 3);
    end
    checkOutput("hold_ovl", ifd.ovl, 0);
    checkOutput("hold_sticky", ifd.ovl_sticky, 0);

    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 16'sd0, 1'b0, 1'b0);
      checkOutput($sformatf("dc0_V[%0d]", i), ifd.V, 3);
    end

    foreach (dcVecs[i]) begin
      applyStimulus(dcVecs[i].en, dcVecs[i].din, dcVecs[i].mute, dcVecs[i].clr);
      checkOutput($sformatf("vec%0d_V", i), ifd.V, dcVecs[i].expV);
      checkOutput($sformatf("vec%0d_ovl", i), ifd.ovl, dcVecs[i].expOvl);
      checkOutput($sformatf("vec%0d_sticky", i), ifd.ovl_sticky, dcVecs[i].expSticky);
    end

    // Fresh start of the din=5461 run, then an asynchronous reset mid-stream
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int n = 0; n < 7; n++) begin
      applyStimulus(1'b1, 16'sd5461, 1'b0, 1'b0);
      checkOutput($sformatf("pre_trace[%0d]", n), ifd.V, trace[n]);
    end
    rstn = 1'b0;
    #1;
    checkOutput("midreset_V", ifd.V, 3);
    checkOutput("midreset_ovl", ifd.ovl, 0);
    checkOutput("midreset_sticky", ifd.ovl_sticky, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    sum = 0; badRange = 0; ovlSeen = 0;
    for (int n = 0; n < 4096; n++) begin
      applyStimulus(1'b1, 16'sd5461, 1'b0, 1'b0);
      v = int'(ifd.V);
      if (n < 8) checkOutput($sformatf("restart_trace[%0d]", n), ifd.V, trace[n]);
      if (v < 2 || v > 5) badRange++;
      if (ifd.ovl !== 1'b0) ovlSeen++;
      sum += v - 3;
    end
    checkOutput("noise_range_violations", badRange, 0);
    checkOutput("noise_ovl_seen", ovlSeen, 0);
    checkOutput("noise_sticky", ifd.ovl_sticky, 0);
    checkRange("noise_sum_q_4096", sum, 2040, 2056);

    ifd.clk_en = 1'b0;
    foreach (ovlVecs[i]) begin
      applyOvl(ovlVecs[i].en, ovlVecs[i].din, ovlVecs[i].clr);
      checkOutput($sformatf("ovl%0d_V", i), ifo.V, ovlVecs[i].expV);
      checkOutput($sformatf("ovl%0d_ovl", i), ifo.ovl, ovlVecs[i].expOvl);
      checkOutput($sformatf("ovl%0d_sticky", i), ifo.ovl_sticky, ovlVecs[i].expSticky);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
